mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_LAT, default 5, SHALL set the busy cycles for mult/multu.
REQ-002 Parameter DIV_LAT, default 10, SHALL set the busy cycles for div/divu.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a one-cycle pulse from E stage launching md_op.
REQ-006 md_op  input  3  SHALL be the operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO (package encodings).
REQ-007 a  input  32  SHALL be the forwarded rs operand.
REQ-008 b  input  32  SHALL be the forwarded rt operand.
REQ-009 d_is_md  input  1  SHALL flag that the D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 busy  output  1  SHALL be high while a multiply/divide is in flight.
REQ-011 md_stall  output  1  SHALL be the stall request ORed into the pipeline stall.
REQ-012 hi  output  32  SHALL be the architectural HI register.
REQ-013 lo  output  32  SHALL be the architectural LO register.

Function
REQ-014 The FSM SHALL have two states, IDLE and BUSY.
REQ-015 In IDLE, start with MULT/MULTU/DIV/DIVU SHALL latch the result into shadow registers, load the counter with the op latency, and go to BUSY next cycle.
REQ-016 In BUSY, the counter SHALL decrement each cycle; at 1 the shadow result SHALL commit to hi/lo and the FSM SHALL return to IDLE, giving busy high for exactly the latency.
REQ-017 hi/lo SHALL hold their old values throughout BUSY.
REQ-018 MULT SHALL form the signed 64-bit a*b, MULTU the unsigned product; hi = [63:32], lo = [31:0].
REQ-019 DIV/DIVU SHALL set lo = quotient and hi = remainder, signed versions truncating toward zero with remainder sign following a.
REQ-020 Division by zero SHALL still run DIV_LAT cycles and leave hi/lo unchanged.
REQ-021 MTHI/MTLO with start in IDLE SHALL write a to hi/lo at the next edge, with no BUSY.
REQ-022 start asserted in BUSY (any op) SHALL be ignored.
REQ-023 md_stall SHALL equal d_is_md & (busy | (start & op is MULT/MULTU/DIV/DIVU)), combinationally.
REQ-024 An invalid md_op with start SHALL be a no-op.

Reset
REQ-025 reset low SHALL immediately force IDLE, counter 0, busy 0, hi 0, lo 0, shadows 0, and abort any in-flight operation without a commit.
REQ-026 Release SHALL be synchronous to clk.

Configuration
REQ-027 With MDU_DIV_EN defined, DIV/DIVU SHALL behave per REQ-019/020.
REQ-028 Without MDU_DIV_EN, DIV/DIVU SHALL be treated as invalid ops (REQ-024), no divider logic SHALL be synthesised, and md_stall SHALL exclude them.

Structure
REQ-029 Shared package mdu_pkg SHALL hold the md_op encodings, state encodings and default latencies.
REQ-030 The datapath SHALL be a sub-module mdu_arith (combinational product/quotient/remainder); mdu_ctrl SHALL own the FSM, counter, shadows and hi/lo.

Verification
REQ-031 MULT a=0xFFFFFFFE(-2), b=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles; hi/lo unchanged during busy.
REQ-033 DIV a=-7, b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV b=0 -> hi/lo unchanged after 10 cycles.
REQ-034 MULT start, with d_is_md=1 on start cycle and the next 5 cycles -> md_stall high all 6 cycles; with d_is_md=0 -> md_stall 0.
REQ-035 reset pulsed low in cycle 3 of a MULT -> busy 0, hi=lo=0 immediately, no later commit.
REQ-036 MTLO a=0x12345678 in IDLE -> lo=0x12345678 next cycle, busy stays 0; MTHI during BUSY -> ignored.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
// Divide support exists only when the MDU_DIV_EN macro is defined.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;

  function automatic logic is_mult_op(logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div_code(logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Ops that occupy the unit for a multi-cycle latency and therefore stall D.
  function automatic logic is_long_op(logic [2:0] op);
`ifdef MDU_DIV_EN
    return is_mult_op(op) || is_div_code(op);
`else
    return is_mult_op(op);
`endif
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: 32x32 product and, with MDU_DIV_EN, quotient/remainder.
// ok_o low means the result must not be committed (divide by zero).
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        ok_o
);

  logic [63:0]        prod_u;
  logic signed [63:0] prod_s;
  logic [63:0]        prod;

  assign prod_u = {32'b0, a_i} * {32'b0, b_i};
  assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod   = (op_i == OP_MULT) ? $unsigned(prod_s) : prod_u;

`ifdef MDU_DIV_EN
  logic        sgn;
  logic [31:0] mag_a, mag_b, q_u, r_u, q, r;

  // Divide magnitudes, then fix signs: quotient truncates toward zero,
  // remainder takes the sign of the dividend.
  assign sgn   = (op_i == OP_DIV);
  assign mag_a = (sgn && a_i[31]) ? (~a_i + 32'd1) : a_i;
  assign mag_b = (sgn && b_i[31]) ? (~b_i + 32'd1) : b_i;
  assign q_u   = (b_i == 32'd0) ? 32'd0 : mag_a / mag_b;
  assign r_u   = (b_i == 32'd0) ? 32'd0 : mag_a % mag_b;
  assign q     = (sgn && (a_i[31] ^ b_i[31])) ? (~q_u + 32'd1) : q_u;
  assign r     = (sgn && a_i[31]) ? (~r_u + 32'd1) : r_u;

  always_comb begin
    hi_o = prod[63:32];
    lo_o = prod[31:0];
    ok_o = 1'b1;
    if (is_div_code(op_i)) begin
      hi_o = r;
      lo_o = q;
      ok_o = (b_i != 32'd0);
    end
  end
`else
  assign hi_o = prod[63:32];
  assign lo_o = prod[31:0];
  assign ok_o = 1'b1;
`endif

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide control: IDLE/BUSY FSM, latency counter, shadow result, HI/LO.
// Divide ops are accepted only when MDU_DIV_EN is defined.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output mdu_state_e  dbg_state
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  mdu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic        commit_q, commit_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [31:0] res_hi, res_lo;
  logic        res_ok;
  logic        long_op;
  logic [CW-1:0] lat_load;

  mdu_arith u_arith (
    .op_i (md_op),
    .a_i  (a),
    .b_i  (b),
    .hi_o (res_hi),
    .lo_o (res_lo),
    .ok_o (res_ok)
  );

  // start is a single-cycle launch pulse with no ready: it is acted on only
  // in IDLE and silently dropped in BUSY; the E stage relies on md_stall.
  assign long_op  = is_long_op(md_op);
  assign lat_load = is_mult_op(md_op) ? CW'(MULT_LAT) : CW'(DIV_LAT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_hi_d  = sh_hi_q;
    sh_lo_d  = sh_lo_q;
    commit_d = commit_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (long_op) begin
            state_d  = ST_BUSY;
            cnt_d    = lat_load;
            sh_hi_d  = res_hi;
            sh_lo_d  = res_lo;
            commit_d = res_ok;
          end else if (md_op == OP_MTHI) begin
            hi_d = a;
          end else if (md_op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          if (commit_q) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sh_hi_q  <= '0;
      sh_lo_q  <= '0;
      commit_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_hi_q  <= sh_hi_d;
      sh_lo_q  <= sh_lo_d;
      commit_q <= commit_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy      = (state_q == ST_BUSY);
  assign md_stall  = d_is_md & (busy | (start & long_op));
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: vector table of ops with hand-derived HI/LO and busy length,
// random multiplies, reset abort and busy-time start sequences.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk, reset, start, d_is_md, busy, md_stall;
  logic [2:0]  md_op;
  logic [31:0] a, b, hi, lo;
  mdu_state_e  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          lat;
  } vec_t;
  vec_t vecs[14];

  mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
    .d_is_md(d_is_md), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] ehi, input logic [31:0] elo, input int lat,
                        input logic dmd);
    int n;
    logic [63:0] want;
    @(negedge clk);
    start = 1'b1; md_op = op; a = va; b = vb; d_is_md = dmd;
    exp_q.push_back({ehi, elo});
    #1 check("stall_start", 32'(md_stall), 32'(dmd && (lat > 0)));
    @(negedge clk);
    start = 1'b0;
    #1;
    n = 0;
    while (busy && n < 40) begin
      check("hold_hi", hi, m_hi);
      check("hold_lo", lo, m_lo);
      check("stall_busy", 32'(md_stall), 32'(dmd));
      check("state_busy", 32'(dbg_state), 32'(ST_BUSY));
      n++;
      @(negedge clk);
      #1;
    end
    check("busy_len", 32'(n), 32'(lat));
    want = exp_q.pop_front();
    check("hi", hi, want[63:32]);
    check("lo", lo, want[31:0]);
    m_hi = want[63:32];
    m_lo = want[31:0];
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; md_op = 3'd0; a = '0; b = '0; d_is_md = 1'b1;
    m_hi = '0; m_lo = '0;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{OP_MTLO,  32'h12345678, 32'd0,        32'h00000001, 32'h12345678, 0};
    vecs[3]  = '{OP_MTHI,  32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'h12345678, 0};
    vecs[4]  = '{3'd6,     32'h00000001, 32'd1,        32'hDEADBEEF, 32'h12345678, 0};
    vecs[5]  = '{3'd7,     32'h00000001, 32'd1,        32'hDEADBEEF, 32'h12345678, 0};
    vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hDEADBEEF, 32'h12345678, 0};
    vecs[7]  = '{OP_DIV,   32'd5,        32'd0,        32'hDEADBEEF, 32'h12345678, 0};
    vecs[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'hDEADBEEF, 32'h12345678, 0};
    vecs[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'hDEADBEEF, 32'h12345678, 0};
    vecs[10] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h12345678, 0};
`ifdef MDU_DIV_EN
    vecs[6].ehi  = 32'hFFFFFFFF; vecs[6].elo  = 32'hFFFFFFFD; vecs[6].lat  = 10;
    vecs[7].ehi  = 32'hFFFFFFFF; vecs[7].elo  = 32'hFFFFFFFD; vecs[7].lat  = 10;
    vecs[8].ehi  = 32'h00000001; vecs[8].elo  = 32'hFFFFFFFD; vecs[8].lat  = 10;
    vecs[9].ehi  = 32'h0000000F; vecs[9].elo  = 32'h0FFFFFFF; vecs[9].lat  = 10;
    vecs[10].ehi = 32'h00000000; vecs[10].elo = 32'h80000000; vecs[10].lat = 10;
`endif
    vecs[11] = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 5};
    vecs[12] = '{OP_MULTU, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFE, 32'h80000001, 5};
    vecs[13] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall", 32'(md_stall), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].op, vecs[i].va, vecs[i].vb, vecs[i].ehi, vecs[i].elo, vecs[i].lat, 1'b1);

    // MULT with no md instruction in D must never stall.
    run_op(OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 5, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      logic [63:0] p;
      logic sg;
      ra = $urandom;
      rb = $urandom;
      sg = 1'($urandom_range(0, 1));
      p = {32'b0, ra} * {32'b0, rb};
      if (sg) begin
        if (ra[31]) p = p - {rb, 32'b0};
        if (rb[31]) p = p - {ra, 32'b0};
      end
      run_op(sg ? OP_MULT : OP_MULTU, ra, rb, p[63:32], p[31:0], 5, 1'b1);
    end

    // Ensure HI/LO are non-zero so the reset clear is observable.
    run_op(OP_MTHI, 32'h0BAD0BAD, 32'd0, 32'h0BAD0BAD, m_lo, 0, 1'b0);
    run_op(OP_MTLO, 32'h0FEE0FEE, 32'd0, 32'h0BAD0BAD, 32'h0FEE0FEE, 0, 1'b0);

    // Reset during cycle 3 of a MULT: immediate clear, no later commit.
    @(negedge clk);
    start = 1'b1; md_op = OP_MULT; a = 32'd5; b = 32'd5; d_is_md = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      check("post_abort_busy", 32'(busy), 32'd0);
      check("post_abort_lo", lo, 32'd0);
    end
    m_hi = '0;
    m_lo = '0;

    // MTHI and MULTU started while busy are ignored.
    @(negedge clk);
    start = 1'b1; md_op = OP_MULT; a = 32'd3; b = 32'd4; d_is_md = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      start = (k == 1) || (k == 2);
      md_op = (k == 1) ? OP_MTHI : OP_MULTU;
      a = 32'hAAAA5555;
      b = 32'hFFFFFFFF;
      #1;
      if (busy) begin
        n++;
        check("busy_hold_hi", hi, 32'd0);
      end
    end
    check("ignore_len", 32'(n), 32'd5);
    check("ignore_hi", hi, 32'd0);
    check("ignore_lo", lo, 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
